// File: rtl/dmem_responder.sv
// Data-port slave for the pipelined core: word RAM, console TX FIFO,
// console status and a free-running cycle counter behind MMIO_BASE.
module dmem_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [29:0] DATA_WORD = MMIO_BASE[31:2];
    localparam logic [29:0] STAT_WORD = DATA_WORD + 30'd1;
    localparam logic [29:0] CYC_WORD  = DATA_WORD + 30'd2;

    logic [31:0]   ram      [RAM_WORDS];
    logic [7:0]    fifoMem  [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycles;

    logic          isRam;
    logic          isData;
    logic          isStat;
    logic          isCyc;
    logic [AW-1:0] ramIdx;
    logic          full;
    logic          empty;
    logic          pop;
    logic          pushOk;
    logic          ovfSet;
    logic          ovfClr;
    logic          unusedAddrBits;

    // Byte offset within a word never matters for decode.
    assign unusedAddrBits = ^a[1:0];

    assign isRam  = (a[31:AW+2] == '0);
    assign isData = (a[31:2] == DATA_WORD);
    assign isStat = (a[31:2] == STAT_WORD);
    assign isCyc  = (a[31:2] == CYC_WORD);
    assign ramIdx = a[AW+1:2];

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifoMem[rdPtr];

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign pop    = tx_valid && tx_ready;
    assign pushOk = we && isData && (!full || pop);
    assign ovfSet = we && isData && full && !pop;
    assign ovfClr = we && isStat && wd[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            if (pop) rdPtr <= rdPtr + PW'(1);
            if (pushOk) wrPtr <= wrPtr + PW'(1);
            if (pushOk && !pop) count <= count + CW'(1);
            else if (pop && !pushOk) count <= count - CW'(1);
            if (ovfSet) overflow <= 1'b1;
            else if (ovfClr) overflow <= 1'b0;
            if (we && isCyc) cycles <= wd;
            else cycles <= cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && isRam) ram[ramIdx] <= wd;
        if (pushOk) fifoMem[wrPtr] <= wd[7:0];
    end

    always_comb begin
        rd = '0;
        unique case (1'b1)
            isRam:   rd = ram[ramIdx];
            isStat:  rd = {16'b0, 8'(count), 5'b0, overflow, full, empty};
            isCyc:   rd = cycles;
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue/array reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'hFFFF0000;
    localparam logic [31:0] STAT = 32'hFFFF0004;
    localparam logic [31:0] CYC  = 32'hFFFF0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clk(clk), .reset(reset), .a(a), .we(we), .wd(wd), .rd(rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: RAM array, byte queue, sticky flag, counter.
    logic [31:0] mRam [64];
    bit          mRamValid [64];
    logic [7:0]  q [$];
    bit          ovf;
    logic [31:0] cyc;
    logic [31:0] mW;
    bit          mPop;

    initial begin
        for (int i = 0; i < 64; i++) mRamValid[i] = 1'b0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            ovf = 1'b0;
            cyc = '0;
        end else begin
            mW = a & 32'hFFFFFFFC;
            mPop = (q.size() != 0) && tx_ready;
            if (mPop) void'(q.pop_front());
            if (we) begin
                if (mW < 32'd256) begin
                    mRam[mW[7:2]] = wd;
                    mRamValid[mW[7:2]] = 1'b1;
                end else if (mW == BASE) begin
                    if (q.size() < 8) q.push_back(wd[7:0]);
                    else ovf = 1'b1;
                end else if (mW == STAT) begin
                    if (wd[2]) ovf = 1'b0;
                end
            end
            if (we && mW == CYC) cyc = wd;
            else cyc = cyc + 32'd1;
        end
    end

    logic [31:0] eRd;
    logic [31:0] cW;
    bit          eKnown;

    always @(negedge clk) begin
        cW = a & 32'hFFFFFFFC;
        eKnown = 1'b1;
        eRd = '0;
        if (cW < 32'd256) begin
            eKnown = mRamValid[cW[7:2]];
            eRd = mRam[cW[7:2]];
        end else if (cW == STAT) begin
            eRd = {16'b0, 8'(q.size()), 5'b0, ovf, q.size() == 8, q.size() == 0};
        end else if (cW == CYC) begin
            eRd = cyc;
        end
        if (eKnown) chk("model rd", rd, eRd);
        chk("model tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) chk("model tx_data", {24'b0, tx_data}, {24'b0, q[0]});
    end

    task automatic drive(input logic [31:0] addr, input logic w,
                         input logic [31:0] d, input logic rdy);
        @(posedge clk);
        #2;
        a = addr;
        we = w;
        wd = d;
        tx_ready = rdy;
    endtask

    logic [7:0] expSeq [8];
    int         sel;

    initial begin
        a = CYC;
        repeat (3) @(posedge clk);
        #2;
        #1 chk("cycles in reset", rd, 32'h0);
        chk("tx_valid in reset", {31'b0, tx_valid}, 32'h0);
        reset = 1'b0;
        drive(CYC, 1'b0, 32'h0, 1'b0);
        #1 chk("cycles first", rd, 32'h1);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("reset status", rd, 32'h1);

        for (int i = 0; i < 64; i++) drive(32'(i * 4), 1'b1, $urandom, 1'b0);
        drive(32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
        drive(32'h10, 1'b0, 32'h0, 1'b0);
        #1 chk("ram 0x10", rd, 32'hDEADBEEF);
        drive(32'h14, 1'b1, 32'h0, 1'b0);
        drive(32'h14, 1'b0, 32'h0, 1'b0);
        #1 chk("ram 0x14", rd, 32'h0);

        for (int i = 0; i < 9; i++) drive(BASE, 1'b1, 32'(8'h41 + i), 1'b0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("full+ovf status", rd, 32'h0806);
        for (int i = 0; i < 8; i++) begin
            drive(STAT, 1'b0, 32'h0, 1'b1);
            #1 chk("drain valid", {31'b0, tx_valid}, 32'h1);
            chk("drain byte", {24'b0, tx_data}, 32'(8'h41 + i));
        end
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("drained status", rd, 32'h0005);
        chk("drained valid", {31'b0, tx_valid}, 32'h0);
        drive(STAT, 1'b1, 32'h4, 1'b0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("ovf cleared", rd, 32'h0001);

        for (int i = 0; i < 8; i++) drive(BASE, 1'b1, 32'(8'h61 + i), 1'b0);
        drive(BASE, 1'b1, 32'h5A, 1'b1);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("push+pop at full", rd, 32'h0802);
        for (int i = 0; i < 7; i++) expSeq[i] = 8'(8'h62 + i);
        expSeq[7] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            drive(STAT, 1'b0, 32'h0, 1'b1);
            #1 chk("wrap byte", {24'b0, tx_data}, {24'b0, expSeq[i]});
        end
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("wrap drained", rd, 32'h0001);

        drive(CYC, 1'b1, 32'hFFFFFFFE, 1'b0);
        drive(CYC, 1'b0, 32'h0, 1'b0);
        #1 chk("cycles load", rd, 32'hFFFFFFFE);
        drive(CYC, 1'b0, 32'h0, 1'b0);
        #1 chk("cycles +1", rd, 32'hFFFFFFFF);
        drive(CYC, 1'b0, 32'h0, 1'b0);
        #1 chk("cycles wrap", rd, 32'h0);

        drive(32'h80000000, 1'b1, 32'h12345678, 1'b0);
        drive(32'h80000000, 1'b0, 32'h0, 1'b0);
        #1 chk("unmapped read", rd, 32'h0);
        drive(32'h10, 1'b0, 32'h0, 1'b0);
        #1 chk("ram intact", rd, 32'hDEADBEEF);

        for (int i = 0; i < 9; i++) drive(BASE, 1'b1, 32'(8'h30 + i), 1'b0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("ovf set again", rd, 32'h0806);
        drive(STAT, 1'b1, 32'h4, 1'b0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("ovf clear write", rd, 32'h0802);
        repeat (8) drive(STAT, 1'b0, 32'h0, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: drive($urandom_range(0, 255), 1'($urandom_range(0, 1)),
                                  $urandom, $urandom_range(0, 2) == 0);
                4, 5: drive(BASE | 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            $urandom, $urandom_range(0, 2) == 0);
                6: drive(STAT, 1'($urandom_range(0, 1)), $urandom,
                         $urandom_range(0, 2) == 0);
                7: drive(CYC, $urandom_range(0, 7) == 0, $urandom,
                         $urandom_range(0, 2) == 0);
                8: drive(32'h100 + 32'($urandom_range(0, 1000)) * 4,
                         1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
                default: drive(BASE + 32'hC, 1'($urandom_range(0, 1)), $urandom,
                               1'($urandom_range(0, 1)));
            endcase
        end

        repeat (10) drive(STAT, 1'b1, 32'h4, 1'b1);
        for (int i = 0; i < 3; i++) drive(BASE, 1'b1, 32'(8'h70 + i), 1'b0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        #1 chk("pre-reset status", rd, 32'h0300);
        reset = 1'b1;
        #1 chk("async tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("async status", rd, 32'h0001);
        @(posedge clk);
        #2;
        reset = 1'b0;
        a = CYC;
        #1 chk("cycles after reset", rd, 32'h0);
        drive(STAT, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
